// File: rtl/tile_dispatcher.sv
// Tile dispatcher: walks a triangle's tile-aligned bounding box in raster order
// and emits one job per tile, stepping edge/z start values incrementally.
module tile_dispatcher #(
    parameter int ACC_BITS    = 32,
    parameter int STEP_BITS   = 16,
    parameter int TILE_LOG2   = 3,
    parameter int TCOORD_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tri_vld,
    output logic                     tri_rdy,
    input  logic [TCOORD_BITS-1:0]   tri_tx0,
    input  logic [TCOORD_BITS-1:0]   tri_ty0,
    input  logic [TCOORD_BITS-1:0]   tri_tx1,
    input  logic [TCOORD_BITS-1:0]   tri_ty1,
    input  logic [3*ACC_BITS-1:0]    tri_edge,
    input  logic [3*STEP_BITS-1:0]   tri_dedx,
    input  logic [3*STEP_BITS-1:0]   tri_dedy,
    input  logic [ACC_BITS-1:0]      tri_z,
    input  logic [STEP_BITS-1:0]     tri_dzdx,
    input  logic [STEP_BITS-1:0]     tri_dzdy,
    input  logic [3:0]               tri_color,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [TCOORD_BITS-1:0]   out_tx,
    output logic [TCOORD_BITS-1:0]   out_ty,
    output logic [3*ACC_BITS-1:0]    out_edge,
    output logic [3*STEP_BITS-1:0]   out_dedx,
    output logic [3*STEP_BITS-1:0]   out_dedy,
    output logic [ACC_BITS-1:0]      out_z,
    output logic [STEP_BITS-1:0]     out_dzdx,
    output logic [STEP_BITS-1:0]     out_dzdy,
    output logic [3:0]               out_color,
    output logic                     out_last,
    output logic                     busy
);

    localparam int EW = 3 * ACC_BITS;
    localparam int SW = 3 * STEP_BITS;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [TCOORD_BITS-1:0] tx0_q, tx0_d, tx1_q, tx1_d, ty1_q, ty1_d;
    logic [TCOORD_BITS-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [EW-1:0]          edge_cur_q, edge_cur_d, edge_row_q, edge_row_d;
    logic [SW-1:0]          dedx_q, dedx_d, dedy_q, dedy_d;
    logic [ACC_BITS-1:0]    z_cur_q, z_cur_d, z_row_q, z_row_d;
    logic [STEP_BITS-1:0]   dzdx_q, dzdx_d, dzdy_q, dzdy_d;
    logic [3:0]             color_q, color_d;

    logic accept, empty, fire, last_tile, row_end;

    // Per-tile step: sign-extend the per-pixel gradient, then scale by tile size.
    function automatic logic [ACC_BITS-1:0] tstep(input logic [STEP_BITS-1:0] g);
        logic [ACC_BITS-1:0] s;
        s = {{(ACC_BITS-STEP_BITS){g[STEP_BITS-1]}}, g};
        return s << TILE_LOG2;
    endfunction

    assign accept    = tri_vld && (state_q == IDLE);
    assign empty     = (tri_tx1 < tri_tx0) || (tri_ty1 < tri_ty0);
    assign fire      = (state_q == EMIT) && out_rdy;
    assign row_end   = (cx_q == tx1_q);
    assign last_tile = row_end && (cy_q == ty1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && !empty) state_d = EMIT;
            EMIT: if (fire && last_tile) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tri_rdy  = 1'b0;
        out_vld  = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: tri_rdy = 1'b1;
            EMIT: begin
                out_vld = 1'b1;
                busy    = 1'b1;
            end
            default: tri_rdy = 1'b0;
        endcase
        out_last = out_vld && last_tile;
    end

    always_comb begin
        tx0_d      = tx0_q;
        tx1_d      = tx1_q;
        ty1_d      = ty1_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        edge_cur_d = edge_cur_q;
        edge_row_d = edge_row_q;
        dedx_d     = dedx_q;
        dedy_d     = dedy_q;
        z_cur_d    = z_cur_q;
        z_row_d    = z_row_q;
        dzdx_d     = dzdx_q;
        dzdy_d     = dzdy_q;
        color_d    = color_q;
        if (accept) begin
            tx0_d      = tri_tx0;
            tx1_d      = tri_tx1;
            ty1_d      = tri_ty1;
            cx_d       = tri_tx0;
            cy_d       = tri_ty0;
            edge_cur_d = tri_edge;
            edge_row_d = tri_edge;
            dedx_d     = tri_dedx;
            dedy_d     = tri_dedy;
            z_cur_d    = tri_z;
            z_row_d    = tri_z;
            dzdx_d     = tri_dzdx;
            dzdy_d     = tri_dzdy;
            color_d    = tri_color;
        end else if (fire && !last_tile) begin
            if (row_end) begin
                // Next row restarts from the row accumulator, not the tile one.
                cx_d = tx0_q;
                cy_d = cy_q + TCOORD_BITS'(1);
                for (int i = 0; i < 3; i++) begin
                    edge_row_d[i*ACC_BITS +: ACC_BITS] =
                        edge_row_q[i*ACC_BITS +: ACC_BITS] +
                        tstep(dedy_q[i*STEP_BITS +: STEP_BITS]);
                end
                edge_cur_d = edge_row_d;
                z_row_d    = z_row_q + tstep(dzdy_q);
                z_cur_d    = z_row_d;
            end else begin
                cx_d = cx_q + TCOORD_BITS'(1);
                for (int i = 0; i < 3; i++) begin
                    edge_cur_d[i*ACC_BITS +: ACC_BITS] =
                        edge_cur_q[i*ACC_BITS +: ACC_BITS] +
                        tstep(dedx_q[i*STEP_BITS +: STEP_BITS]);
                end
                z_cur_d = z_cur_q + tstep(dzdx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx0_q      <= '0;
            tx1_q      <= '0;
            ty1_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            edge_cur_q <= '0;
            edge_row_q <= '0;
            dedx_q     <= '0;
            dedy_q     <= '0;
            z_cur_q    <= '0;
            z_row_q    <= '0;
            dzdx_q     <= '0;
            dzdy_q     <= '0;
            color_q    <= '0;
        end else begin
            tx0_q      <= tx0_d;
            tx1_q      <= tx1_d;
            ty1_q      <= ty1_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            edge_cur_q <= edge_cur_d;
            edge_row_q <= edge_row_d;
            dedx_q     <= dedx_d;
            dedy_q     <= dedy_d;
            z_cur_q    <= z_cur_d;
            z_row_q    <= z_row_d;
            dzdx_q     <= dzdx_d;
            dzdy_q     <= dzdy_d;
            color_q    <= color_d;
        end
    end

    assign out_tx    = cx_q;
    assign out_ty    = cy_q;
    assign out_edge  = edge_cur_q;
    assign out_dedx  = dedx_q;
    assign out_dedy  = dedy_q;
    assign out_z     = z_cur_q;
    assign out_dzdx  = dzdx_q;
    assign out_dzdy  = dzdy_q;
    assign out_color = color_q;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Bench for tile_dispatcher: random triangles against a closed-form tile model,
// checked by a scoreboard monitor decoupled from the stimulus.
module tb_tile_dispatcher;

    typedef struct packed {
        logic [5:0]  tx0, ty0, tx1, ty1;
        logic [95:0] edge_v;
        logic [47:0] dedx, dedy;
        logic [31:0] z;
        logic [15:0] dzdx, dzdy;
        logic [3:0]  color;
    } desc_t;

    typedef struct packed {
        logic [5:0]  tx, ty;
        logic [95:0] edge_v;
        logic [31:0] z;
        logic [47:0] dedx, dedy;
        logic [15:0] dzdx, dzdy;
        logic [3:0]  color;
        logic        last;
    } job_t;

    logic        clk, rst_n;
    logic        tri_vld, tri_rdy;
    logic [5:0]  tri_tx0, tri_ty0, tri_tx1, tri_ty1;
    logic [95:0] tri_edge;
    logic [47:0] tri_dedx, tri_dedy;
    logic [31:0] tri_z;
    logic [15:0] tri_dzdx, tri_dzdy;
    logic [3:0]  tri_color;
    logic        out_vld, out_rdy;
    logic [5:0]  out_tx, out_ty;
    logic [95:0] out_edge;
    logic [47:0] out_dedx, out_dedy;
    logic [31:0] out_z;
    logic [15:0] out_dzdx, out_dzdy;
    logic [3:0]  out_color;
    logic        out_last, busy;

    tile_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .tri_vld(tri_vld), .tri_rdy(tri_rdy),
        .tri_tx0(tri_tx0), .tri_ty0(tri_ty0),
        .tri_tx1(tri_tx1), .tri_ty1(tri_ty1),
        .tri_edge(tri_edge), .tri_dedx(tri_dedx), .tri_dedy(tri_dedy),
        .tri_z(tri_z), .tri_dzdx(tri_dzdx), .tri_dzdy(tri_dzdy),
        .tri_color(tri_color),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_tx(out_tx), .out_ty(out_ty),
        .out_edge(out_edge), .out_dedx(out_dedx), .out_dedy(out_dedy),
        .out_z(out_z), .out_dzdx(out_dzdx), .out_dzdy(out_dzdy),
        .out_color(out_color), .out_last(out_last), .busy(busy)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_hs_cyc = -10;
    job_t q[$];
    bit   pat[$];
    bit   pat_next[$];
    bit   rnd_rdy = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input string det);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", nm, det);
        end
    endtask

    // Reference: value at tile (x,y) = origin + 8*((x-tx0)*gx + (y-ty0)*gy), mod 2^32.
    function automatic void push_jobs(input desc_t d);
        job_t    j;
        shortint gx, gy;
        int      e, dx, dy;
        for (int y = int'(d.ty0); y <= int'(d.ty1); y++) begin
            for (int x = int'(d.tx0); x <= int'(d.tx1); x++) begin
                dx = x - int'(d.tx0);
                dy = y - int'(d.ty0);
                j.tx = 6'(x);
                j.ty = 6'(y);
                for (int i = 0; i < 3; i++) begin
                    gx = d.dedx[i*16 +: 16];
                    gy = d.dedy[i*16 +: 16];
                    e = int'(d.edge_v[i*32 +: 32]) + dx * int'(gx) * 8 + dy * int'(gy) * 8;
                    j.edge_v[i*32 +: 32] = e;
                end
                gx = d.dzdx;
                gy = d.dzdy;
                j.z     = int'(d.z) + dx * int'(gx) * 8 + dy * int'(gy) * 8;
                j.dedx  = d.dedx;
                j.dedy  = d.dedy;
                j.dzdx  = d.dzdx;
                j.dzdy  = d.dzdy;
                j.color = d.color;
                j.last  = (x == int'(d.tx1)) && (y == int'(d.ty1));
                q.push_back(j);
            end
        end
    endfunction

    function automatic job_t sample();
        job_t a;
        a = '{out_tx, out_ty, out_edge, out_z, out_dedx, out_dedy,
              out_dzdx, out_dzdy, out_color, out_last};
        return a;
    endfunction

    always @(posedge clk) begin
        #1;
        if (pat.size() > 0) out_rdy = pat.pop_front();
        else if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
        else out_rdy = 1'b1;
    end

    job_t act, exp_j, held;
    bit   held_v = 0;
    bit   after_last = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 0;
            after_last = 0;
        end else begin
            act = sample();
            check(busy == out_vld && tri_rdy == !out_vld && (!out_last || out_vld),
                  "status", $sformatf("vld=%b busy=%b rdy=%b last=%b",
                                      out_vld, busy, tri_rdy, out_last));
            if (after_last)
                check(tri_rdy && !out_vld, "idle_after_last",
                      $sformatf("tri_rdy=%b out_vld=%b want 1/0", tri_rdy, out_vld));
            after_last = 0;
            if (held_v)
                check(out_vld && act === held, "stall_hold",
                      $sformatf("vld=%b got tx=%0d ty=%0d e=%h z=%h held tx=%0d ty=%0d e=%h z=%h",
                                out_vld, act.tx, act.ty, act.edge_v, act.z,
                                held.tx, held.ty, held.edge_v, held.z));
            held_v = 0;
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    check(0, "unexpected_job",
                          $sformatf("got tx=%0d ty=%0d with no job expected", act.tx, act.ty));
                end else begin
                    exp_j = q.pop_front();
                    check(act === exp_j, "job",
                          $sformatf("got tx=%0d ty=%0d e=%h z=%h last=%b c=%h exp tx=%0d ty=%0d e=%h z=%h last=%b c=%h",
                                    act.tx, act.ty, act.edge_v, act.z, act.last, act.color,
                                    exp_j.tx, exp_j.ty, exp_j.edge_v, exp_j.z, exp_j.last, exp_j.color));
                end
                if (out_last) begin
                    last_hs_cyc = cyc;
                    after_last = 1;
                end
            end else if (out_vld) begin
                held = act;
                held_v = 1;
            end
        end
    end

    function automatic desc_t mk(input int x0, input int y0, input int x1, input int y1);
        desc_t d;
        d.tx0 = 6'(x0); d.ty0 = 6'(y0); d.tx1 = 6'(x1); d.ty1 = 6'(y1);
        d.edge_v = {$urandom(), $urandom(), $urandom()};
        d.dedx   = 48'({$urandom(), $urandom()});
        d.dedy   = 48'({$urandom(), $urandom()});
        d.z      = $urandom();
        d.dzdx   = 16'($urandom());
        d.dzdy   = 16'($urandom());
        d.color  = 4'($urandom());
        return d;
    endfunction

    task automatic send(input desc_t d, input bit b2b);
        int n;
        bit ne;
        ne = (d.tx1 >= d.tx0) && (d.ty1 >= d.ty0);
        @(posedge clk);
        #1;
        tri_tx0 = d.tx0; tri_ty0 = d.ty0; tri_tx1 = d.tx1; tri_ty1 = d.ty1;
        tri_edge = d.edge_v; tri_dedx = d.dedx; tri_dedy = d.dedy;
        tri_z = d.z; tri_dzdx = d.dzdx; tri_dzdy = d.dzdy; tri_color = d.color;
        tri_vld = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tri_rdy && n < 500);
        if (!tri_rdy) begin
            check(0, "accept_timeout", $sformatf("tri_rdy=0 after %0d cycles", n));
            tri_vld = 0;
            return;
        end
        if (b2b)
            check(cyc == last_hs_cyc + 1, "b2b_accept",
                  $sformatf("accepted cycle %0d want %0d", cyc, last_hs_cyc + 1));
        push_jobs(d);
        @(posedge clk);
        pat = pat_next;
        pat_next.delete();
        #1;
        tri_vld = 0;
        @(negedge clk);
        if (ne)
            check(out_vld && busy && !tri_rdy, "first_job_latency",
                  $sformatf("vld=%b busy=%b rdy=%b want 1/1/0", out_vld, busy, tri_rdy));
        else
            check(!out_vld && !busy && tri_rdy, "empty_discard",
                  $sformatf("vld=%b busy=%b rdy=%b want 0/0/1", out_vld, busy, tri_rdy));
    endtask

    task automatic drain(output int n);
        n = 0;
        while (q.size() > 0 && n < 10000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() > 0) begin
            check(0, "drain_timeout", $sformatf("%0d jobs never emitted", q.size()));
            q.delete();
        end
    endtask

    initial begin
        desc_t d, d2;
        int    n, x0, y0, x1, y1;
        bit    prev_ne;
        rst_n = 0; tri_vld = 0; out_rdy = 1;
        tri_tx0 = 0; tri_ty0 = 0; tri_tx1 = 0; tri_ty1 = 0;
        tri_edge = 0; tri_dedx = 0; tri_dedy = 0; tri_z = 0;
        tri_dzdx = 0; tri_dzdy = 0; tri_color = 0;
        @(negedge clk);
        @(negedge clk);
        check(!out_vld && !out_last && !busy, "reset_ctrl",
              $sformatf("vld=%b last=%b busy=%b want 0", out_vld, out_last, busy));
        check(out_edge == 0 && out_z == 0 && out_tx == 0 && out_ty == 0 &&
              out_dedx == 0 && out_dzdx == 0 && out_color == 0, "reset_data",
              $sformatf("edge=%h z=%h tx=%0d ty=%0d", out_edge, out_z, out_tx, out_ty));
        @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        check(tri_rdy, "reset_rdy", $sformatf("tri_rdy=%b want 1", tri_rdy));

        d = mk(0, 0, 1, 1);
        d.edge_v[31:0] = 100; d.dedx[15:0] = 2; d.dedy[15:0] = 16'hFFFD;
        d.z = 1000; d.dzdx = 1; d.dzdy = 4;
        send(d, 0);
        drain(n);
        check(n == 4, "throughput", $sformatf("4 jobs took %0d cycles want 4", n));

        pat_next = '{1, 0, 0, 1, 0, 1, 1};
        send(d, 0);
        drain(n);
        repeat (3) @(posedge clk);

        send(mk(3, 0, 2, 0), 0);
        send(mk(5, 7, 5, 7), 0);
        drain(n);
        check(n == 1, "single_tile", $sformatf("took %0d cycles want 1", n));

        d = mk(10, 20, 12, 21);
        d2 = mk(40, 3, 41, 5);
        send(d, 0);
        send(d2, 1);
        drain(n);

        send(mk(0, 0, 1, 1), 0);
        n = 0;
        while (q.size() > 2 && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        check(out_vld && q.size() == 2, "mid_walk",
              $sformatf("vld=%b pending=%0d want 1/2", out_vld, q.size()));
        rst_n = 0;
        #1;
        check(!out_vld && !busy, "async_drop",
              $sformatf("vld=%b busy=%b want 0/0", out_vld, busy));
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        check(tri_rdy && !out_vld && out_edge == 0 && out_tx == 0, "post_reset",
              $sformatf("rdy=%b vld=%b edge=%h tx=%0d", tri_rdy, out_vld, out_edge, out_tx));
        repeat (10) @(posedge clk);

        send(mk(0, 0, 63, 63), 0);
        drain(n);
        check(n == 4096, "full_range", $sformatf("took %0d cycles want 4096", n));

        rnd_rdy = 1;
        prev_ne = 0;
        for (int k = 0; k < 40; k++) begin
            x0 = $urandom_range(1, 62);
            y0 = $urandom_range(1, 62);
            x1 = ($urandom_range(0, 5) == 0) ? x0 - 1 : x0 + $urandom_range(0, 3);
            y1 = ($urandom_range(0, 5) == 0) ? y0 - 1 : y0 + $urandom_range(0, 2);
            if (x1 > 63) x1 = 63;
            if (y1 > 63) y1 = 63;
            d = mk(x0, y0, x1, y1);
            send(d, prev_ne);
            prev_ne = (x1 >= x0) && (y1 >= y0);
        end
        drain(n);
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_dispatcher.md
Name: tile_dispatcher

Overview:
Front-end sequencer for the pixel processor. It accepts one setup triangle descriptor at a time, holding a tile-aligned bounding box plus edge and depth values at the first tile's origin. It walks the box in raster order (x inner, y outer) and emits one per-tile job per tile over a valid/ready handshake. Per-tile edge and z start values are produced by incremental tile-step addition, so the pixel processor needs no multipliers.

Parameters:
ACC_BITS, 32, width of edge/z accumulators (signed, two's complement)
STEP_BITS, 16, width of per-pixel edge/z gradients (signed)
TILE_LOG2, 3, log2 of tile edge length in pixels (8x8 tiles)
TCOORD_BITS, 6, width of tile coordinates (unsigned)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tri_vld  in  1  descriptor valid
tri_rdy  out  1  dispatcher can accept descriptor
tri_tx0, tri_ty0  in  TCOORD_BITS each  first tile (inclusive)
tri_tx1, tri_ty1  in  TCOORD_BITS each  last tile (inclusive)
tri_edge  in  3*ACC_BITS  edge values E0..E2 at origin of tile (tx0,ty0); Ei at [i*ACC_BITS +: ACC_BITS]
tri_dedx  in  3*STEP_BITS  per-pixel x gradient of each edge
tri_dedy  in  3*STEP_BITS  per-pixel y gradient of each edge
tri_z  in  ACC_BITS  depth at origin of first tile
tri_dzdx, tri_dzdy  in  STEP_BITS each  per-pixel depth gradients
tri_color  in  4  flat color
out_vld  out  1  tile job valid
out_rdy  in  1  pixel processor ready
out_tx, out_ty  out  TCOORD_BITS each  tile coordinate of job
out_edge  out  3*ACC_BITS  edge values at tile origin
out_dedx, out_dedy  out  3*STEP_BITS each  gradients, passed through from latched descriptor
out_z  out  ACC_BITS  depth at tile origin
out_dzdx, out_dzdy  out  STEP_BITS each  passed through
out_color  out  4  passed through
out_last  out  1  job is final tile of triangle
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; out_vld=0, out_last=0, busy=0; all data outputs 0. tri_rdy=1 once reset releases.
- Reset is asynchronous. Asserting it mid-walk drops the triangle immediately: out_vld falls without waiting for a clock edge, and no partial state is retained.
- FSM states: IDLE, EMIT.
- tri_rdy = (state==IDLE), decoded from the state register only. It has no combinational path from out_rdy.
- IDLE, on tri_vld && tri_rdy:
  - Latch all descriptor fields.
  - If tri_tx1<tri_tx0 or tri_ty1<tri_ty0: empty box. Discard it, stay IDLE, emit nothing.
  - Otherwise: cur=(tx0,ty0), edge_cur=edge_row=tri_edge, z_cur=z_row=tri_z, go to EMIT.
  - First job is visible (out_vld=1) in the cycle after acceptance.
- EMIT:
  - out_vld=1. All out_* fields come straight from registers.
  - out_last = (cur_x==tx1 && cur_y==ty1).
  - While out_rdy=0, every output holds stable.
  - On out_vld && out_rdy:
    - If last tile: go to IDLE. out_vld=0 in the next cycle; tri_rdy=1 in the next cycle.
    - Else if cur_x==tx1: cur_x=tx0, cur_y+=1, edge_row += sx(dedy)<<TILE_LOG2, edge_cur = new edge_row. Same for z_row/z_cur with dzdy.
    - Else: cur_x+=1, edge_cur += sx(dedx)<<TILE_LOG2, z_cur += sx(dzdx)<<TILE_LOG2.
- Throughput: one tile job per cycle under continuous out_rdy. There is one idle cycle between triangles (EMIT→IDLE→accept→EMIT).
- Arithmetic:
  - Gradients are sign-extended to ACC_BITS before the shift.
  - Sums wrap modulo 2^ACC_BITS with no saturation or overflow flag.
  - Three edges update in parallel, each with its own gradient.
- Single-tile box (tx0==tx1, ty0==ty1): one job with out_last=1.
- Full-range box (0..2^TCOORD_BITS-1 on each axis): coordinate counters must not wrap before the last-tile compare fires.
- A descriptor presented during EMIT is not accepted (tri_rdy=0). The upstream must hold it.
- busy=1 throughout EMIT and 0 in IDLE.

Test Plan:
- 2x2 box (0,0)-(1,1), E0=100, dedx0=2, dedy0=-3, z=1000, dzdx=1, dzdy=4, out_rdy=1 -> four jobs on consecutive cycles:
  - (0,0) E0=100, z=1000
  - (1,0) E0=116, z=1008
  - (0,1) E0=76, z=1032
  - (1,1) E0=92, z=1040, out_last=1
  - tri_rdy returns 1 in the cycle after the last handshake.
- Same 2x2 box with out_rdy toggling 1,0,0,1,0,1,1 -> exactly four handshakes in the same order and values, with outputs stable while stalled.
- Empty box tx0=3, tx1=2 -> descriptor accepted, no out_vld ever, busy stays 0, next descriptor accepted the following cycle.
- Single tile (5,7)-(5,7) -> one job, tile (5,7), out_last=1, edge/z equal to inputs.
- Back-to-back triangles held on tri_vld -> second is accepted exactly one cycle after the first's last handshake, and jobs never interleave.
- rst_n pulsed low mid-walk (after 2 of 4 tiles) -> out_vld=0 immediately. After release: IDLE, tri_rdy=1, no further jobs from the old triangle.
